// File: rtl/pc_fetch_seq_pkg.sv
// ============================================================================
// pc_fetch_seq_pkg : shared types and constants for the PC fetch sequencer
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pc_seq_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEF_INC          = 4;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// pc_next_sel : redirect target alignment, misalign detection and next-PC
//               priority select (jump > branch > pending > sequential)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pc_next_sel
  import pc_fetch_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INC   = DEF_INC
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  output logic             redir_valid,
  output logic [WIDTH-1:0] redir_target,
  output logic             misalign,
  output logic [WIDTH-1:0] xfer_pc
);

  localparam logic [WIDTH-1:0] C_KEEP = {{(WIDTH-2){1'b1}}, ~ALIGN_MASK};

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_seq;

  // Jump overrides branch whenever both are presented together.
  assign w_raw        = jump ? jump_target : branch_target;
  assign redir_valid  = jump | branch_taken;
  assign redir_target = w_raw & C_KEEP;
  assign misalign     = redir_valid && ((w_raw[1:0] & ALIGN_MASK) != 2'b00);
  assign w_seq        = pc + WIDTH'(INC);
  assign xfer_pc      = redir_valid ? redir_target :
                        pend_valid  ? pend_target  : w_seq;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// pc_fetch_sequencer : PC sequencing and instruction-fetch handshake control
// Optional perf counters enabled by macro PC_FETCH_SEQ_PERF_EN
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pc_fetch_sequencer
  import pc_fetch_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int               INC          = DEF_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             fetch_ack,
  output logic [WIDTH-1:0] pc_out,
  output logic             fetch_req,
  output logic             halted,
  output logic             misalign_err
`ifdef PC_FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  pc_seq_state_t    r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_req;
  logic             r_halted;
  logic             r_mis;
  logic             r_pend_v;
  logic [WIDTH-1:0] r_pend;

  logic             w_xfer;
  logic             w_redir;
  logic [WIDTH-1:0] w_redir_target;
  logic             w_misalign;
  logic [WIDTH-1:0] w_xfer_pc;

  assign w_xfer = r_req & fetch_ack;

  pc_next_sel #(.WIDTH(WIDTH), .INC(INC)) u_next_sel (
    .pc            (r_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pend_valid    (r_pend_v),
    .pend_target   (r_pend),
    .redir_valid   (w_redir),
    .redir_target  (w_redir_target),
    .misalign      (w_misalign),
    .xfer_pc       (w_xfer_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_VECTOR;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
      r_mis    <= 1'b0;
      r_pend_v <= 1'b0;
      r_pend   <= '0;
    end else begin
      if (w_misalign)
        r_mis <= 1'b1;

      // PC/pending update depends only on whether a request is outstanding.
      if (r_req) begin
        if (w_xfer) begin
          r_pc     <= w_xfer_pc;
          r_pend_v <= 1'b0;
        end else if (w_redir) begin
          r_pend_v <= 1'b1;
          r_pend   <= w_redir_target;
        end
      end else if (w_redir) begin
        r_pc <= w_redir_target;
      end

      case (r_state)
        IDLE: begin
          if (start)
            r_state <= RUN;
        end
        RUN: begin
          if (r_req && !w_xfer) begin
            if (halt)
              r_state <= DRAIN;
          end else if (halt) begin
            r_state  <= HALTED;
            r_req    <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_req <= !stall;
          end
        end
        DRAIN: begin
          if (w_xfer) begin
            r_state  <= HALTED;
            r_req    <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt && start) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc_out       = r_pc;
  assign fetch_req    = r_req;
  assign halted       = r_halted;
  assign misalign_err = r_mis;

`ifdef PC_FETCH_SEQ_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_xfer && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == RUN) && stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// ============================================================================
// tb_pc_fetch_sequencer : table-driven checks of the PC fetch sequencer
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, stall, jump, branch_taken, fetch_ack;
  logic [31:0] jump_target, branch_target;
  logic [31:0] pc_out;
  logic        fetch_req, halted, misalign_err;
`ifdef PC_FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt          (halt),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_ack     (fetch_ack),
    .pc_out        (pc_out),
    .fetch_req     (fetch_req),
    .halted        (halted),
    .misalign_err  (misalign_err)
`ifdef PC_FETCH_SEQ_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic        start, halt, stall, jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        ack;
    logic [31:0] epc;
    logic        ereq, eh, em;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic st, input logic hl, input logic sl, input logic j,
                     input logic [31:0] jt, input logic b, input logic [31:0] bt,
                     input logic a, input logic [31:0] epc, input logic er,
                     input logic eh, input logic em);
    vec_t v;
    v.start = st; v.halt = hl; v.stall = sl; v.jump = j; v.jt = jt;
    v.br = b; v.bt = bt; v.ack = a; v.epc = epc; v.ereq = er; v.eh = eh; v.em = em;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic er,
                         input logic eh, input logic em);
    chk({tag, " pc_out"}, pc_out, epc);
    chk({tag, " fetch_req"}, {31'd0, fetch_req}, {31'd0, er});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, eh});
    chk({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, em});
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; stall = 0; jump = 0; branch_taken = 0; fetch_ack = 0;
    jump_target = '0; branch_target = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    //  st hl sl j  jt            b  bt          ack  pc            req h  m
    add(1, 0, 0, 0, 0,            0, 0,          0,   32'h0,        0, 0, 0); // IDLE->RUN
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h0,        1, 0, 0); // request rises
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h4,        1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h8,        1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'hC,        1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'hC,        1, 0, 0); // un-acked hold
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'hC,        1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'hC,        1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h10,       1, 0, 0);
    add(0, 0, 0, 0, 0,            1, 32'h40,     0,   32'h10,       1, 0, 0); // branch pending
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'h10,       1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h40,       1, 0, 0); // pending consumed
    add(0, 0, 0, 1, 32'h80,       1, 32'h40,     1,   32'h80,       1, 0, 0); // jump beats branch
    add(0, 0, 0, 1, 32'h100,      1, 32'h200,    0,   32'h80,       1, 0, 0); // pending = jump
    add(0, 0, 0, 0, 0,            1, 32'h300,    0,   32'h80,       1, 0, 0); // newer overwrites
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h300,      1, 0, 0);
    add(0, 0, 1, 0, 0,            0, 0,          1,   32'h304,      0, 0, 0); // stall after xfer
    add(0, 0, 1, 0, 0,            0, 0,          1,   32'h304,      0, 0, 0); // ack ignored
    add(0, 0, 1, 0, 0,            0, 0,          0,   32'h304,      0, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'h304,      1, 0, 0); // stall released
    add(0, 0, 1, 0, 0,            0, 0,          1,   32'h308,      0, 0, 0);
    add(0, 0, 1, 1, 32'h500,      0, 0,          0,   32'h500,      0, 0, 0); // direct redirect
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'h500,      1, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,          0,   32'h500,      1, 0, 0); // DRAIN
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'h500,      1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h504,      0, 1, 0); // HALTED
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h504,      0, 1, 0);
    add(1, 1, 0, 0, 0,            0, 0,          0,   32'h504,      0, 1, 0); // halt beats start
    add(1, 0, 0, 0, 0,            0, 0,          0,   32'h504,      0, 0, 0); // resume
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h504,      1, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h508,      1, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,          1,   32'h50C,      0, 1, 0); // halt on xfer
    add(1, 0, 0, 0, 0,            0, 0,          0,   32'h50C,      0, 0, 0);
    add(0, 0, 0, 0, 0,            0, 0,          0,   32'h50C,      1, 0, 0);
    add(0, 1, 0, 1, 32'h600,      0, 0,          0,   32'h50C,      1, 0, 0); // halt + redirect
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h600,      0, 1, 0);
    add(0, 0, 0, 1, 32'h643,      0, 0,          0,   32'h640,      0, 1, 1); // misaligned
    add(1, 0, 0, 0, 0,            0, 0,          0,   32'h640,      0, 0, 1);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h640,      1, 0, 1);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h644,      1, 0, 1);
    add(0, 0, 0, 1, 32'hFFFF_FFFC,0, 0,          1,   32'hFFFF_FFFC,1, 0, 1);
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h0,        1, 0, 1); // wrap
    add(0, 0, 0, 0, 0,            0, 0,          1,   32'h4,        1, 0, 1);

    foreach (tbl[i]) begin
      start = tbl[i].start; halt = tbl[i].halt; stall = tbl[i].stall;
      jump = tbl[i].jump; jump_target = tbl[i].jt;
      branch_taken = tbl[i].br; branch_target = tbl[i].bt; fetch_ack = tbl[i].ack;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].epc, tbl[i].ereq, tbl[i].eh, tbl[i].em);
    end

    // Asynchronous reset in the middle of an outstanding request.
    idle_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset_idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Restart after reset begins fetching from the reset vector.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fetch_ack = 1'b1;
    @(posedge clk);
    #1;
    chk_all("restart_req", 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("restart_adv", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
